// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver showing a frame-latched 32-bit word as hex.
// Optional leading-zero blanking is enabled by defining SEG7_BLANK_EN.
module seg7_scan #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Din,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt;
   logic [2:0]    digit;
   logic [31:0]   snap;
   logic          frame_start;
   logic [31:0]   v;
   logic [3:0]    nib;
   logic [6:0]    seg_dec;
   logic          show;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Din is used directly on the frame-start cycle so the first lit digit is never stale.
   assign frame_start = (cnt == '0) && (digit == 3'd0);
   assign v           = frame_start ? Din : snap;
   assign nib         = v[{digit, 2'b00} +: 4];
   assign seg_dec     = hex7(nib);

`ifdef SEG7_BLANK_EN
   logic [2:0] lead;

   always_comb begin
      lead = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (v[4*i +: 4] != 4'h0) lead = 3'(i);
      end
   end

   assign show = (digit <= lead);
`else
   assign show = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         digit <= 3'd0;
         snap  <= 32'h0;
         an    <= 8'hFF;
         seg   <= 7'h7F;
         dp    <= 1'b1;
      end else begin
         if (cnt == CNT_MAX) begin
            cnt   <= '0;
            digit <= digit + 3'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (frame_start) snap <= Din;
         if (show) begin
            an  <= ~(8'b1 << digit);
            seg <= seg_dec;
         end else begin
            an  <= 8'hFF;
            seg <= 7'h7F;
         end
         dp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan at REFRESH_DIV=4: stimulus pushes expected outputs, a monitor pops and checks.
// Define SEG7_BLANK_EN for both files to exercise leading-zero blanking.
module tb_seg7_scan;

   logic        clk;
   logic        rst;
   logic [31:0] Din;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   logic [15:0] exp_q[$];
   string       lbl_q[$];
   int          check_cnt = 0;
   int          pass_cnt  = 0;
   logic [15:0] mon_e;
   string       mon_l;

   seg7_scan #(.REFRESH_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .Din (Din),
      .an  (an),
      .seg (seg),
      .dp  (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
      $fatal(1);
   end

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] tbl [16];
      tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return tbl[n];
   endfunction

   function automatic logic [15:0] expect_digit(input logic [31:0] w, input int d);
      logic [3:0] n;
      logic [7:0] a;
      n = w[4*d +: 4];
      a = ~(8'b1 << d);
`ifdef SEG7_BLANK_EN
      begin
         int k;
         k = 0;
         for (int i = 1; i < 8; i++) if (w[4*i +: 4] != 4'h0) k = i;
         if (d > k) return {8'hFF, 7'h7F, 1'b1};
      end
`endif
      return {a, hex7(n), 1'b1};
   endfunction

   task automatic cyc(input logic r, input logic [31:0] d, input logic [15:0] e, input string name);
      @(negedge clk);
      rst = r;
      Din = d;
      exp_q.push_back(e);
      lbl_q.push_back(name);
   endtask

   task automatic frame(input logic [31:0] drive, input logic [31:0] shown, input string name);
      for (int c = 0; c < 32; c++) cyc(1'b0, drive, expect_digit(shown, c / 4), name);
   endtask

   // Monitor: the DUT presents a new output word every clock edge.
   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_l = lbl_q.pop_front();
         check_cnt++;
         if ({an, seg, dp} === mon_e) pass_cnt++;
         else $display("FAIL %s @%0t: got an=%h seg=%b dp=%b, required an=%h seg=%b dp=%b",
                       mon_l, $time, an, seg, dp, mon_e[15:8], mon_e[7:1], mon_e[0]);
      end
   end

   initial begin
      logic [6:0] sweep [8];
      sweep = '{7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
                7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000};
      rst = 1'b1;
      Din = 32'hFFFF_FFFF;

      for (int i = 0; i < 3; i++) cyc(1'b1, 32'hFFFF_FFFF, {8'hFF, 7'h7F, 1'b1}, "reset");

      for (int c = 1; c <= 32; c++)
         cyc(1'b0, (c >= 10) ? 32'h1234_5678 : 32'h0000_00FF,
             expect_digit(32'h0000_00FF, (c - 1) / 4), "scan");

      frame(32'h1234_5678, 32'h1234_5678, "snapshot");

      for (int c = 0; c < 32; c++)
         cyc(1'b0, 32'h89AB_CDEF, {~(8'b1 << (c / 4)), sweep[c / 4], 1'b1}, "decode");

      for (int c = 0; c < 22; c++)
         cyc(1'b0, 32'h89AB_CDEF, expect_digit(32'h89AB_CDEF, c / 4), "pre_reset");
      cyc(1'b1, 32'hCAFE_0123, {8'hFF, 7'h7F, 1'b1}, "midscan_rst");
      cyc(1'b0, 32'hCAFE_0123, {8'hFE, 7'b0110000, 1'b1}, "reload_first");
      for (int c = 1; c < 32; c++)
         cyc(1'b0, 32'hCAFE_0123, expect_digit(32'hCAFE_0123, c / 4), "reload");

      frame(32'h0000_00FF, 32'h0000_00FF, "blank_ff");
      frame(32'h0000_0000, 32'h0000_0000, "zero");

      @(negedge clk);
      @(negedge clk);
      check_cnt++;
      if (exp_q.size() == 0) pass_cnt++;
      else $display("FAIL drain: %0d entries left, required 0", exp_q.size());

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
